// File: rtl/nbit_serializer.sv
// nbit_serializer: UART-style frame transmitter.
// A frame is one low start bit, n data bits sent LSB first, and one high
// stop bit, with each bit held for CLKS_PER_BIT clocks. The line idles high.
//
// Handshake: a word is accepted on the rising edge where start=1 and ready=1.
// On that edge in0 is copied into the shift register, so later changes on in0
// do not affect the frame. start while ready=0 is dropped, not queued. ready
// rises together with the one-cycle done pulse when the frame ends, and a start
// held high in that cycle is accepted and begins the next frame.
module nbit_serializer #(
    parameter int n            = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] in0,
    input  logic         start,
    output logic         ready,
    output logic         tx,
    output logic         done,
    output logic [1:0]   state_dbg
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(n - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [n-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            baud_end;

    // Next-state logic: baud counter paces each bit, bit counter walks the data bits.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        ready_d  = ready_q;
        done_d   = done_q;
        baud_end = (baud_q == BAUD_LAST);

        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (start && ready_q) begin
                    shreg_d = in0;
                    state_d = START;
                    ready_d = 1'b0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and returns the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign tx        = tx_q;
    assign ready     = ready_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: doc/nbit_serializer.md
NBIT_SERIALIZER -- requirements
Module: nbit_serializer

Interface
REQ-001 The block SHALL have parameter: n, 16, data word width in bits (n >= 1).
REQ-002 The block SHALL have parameter: CLKS_PER_BIT, 4, clock cycles per serial bit period (>= 1).
REQ-003 The block SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port: in0  input  n  parallel word to transmit, sampled only on accepted start.
REQ-006 The block SHALL have port: start  input  1  request to transmit in0.
REQ-007 The block SHALL have port: ready  output  1  high when idle and able to accept start.
REQ-008 The block SHALL have port: tx  output  1  serial line, idle-high.
REQ-009 The block SHALL have port: done  output  1  one-cycle pulse on frame completion.
REQ-010 All outputs SHALL be driven directly from registers (no combinational paths from inputs to outputs).

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-012 A start SHALL be accepted only at a rising edge where start=1 and ready=1; at that edge (edge k) the block SHALL latch in0 into the shift register, enter START, and set ready<=0 and tx<=0.
REQ-013 start while ready=0 SHALL be ignored (no queuing); in0 changes after edge k SHALL NOT affect the frame in progress.
REQ-014 START SHALL hold tx=0 for exactly CLKS_PER_BIT cycles.
REQ-015 DATA SHALL send bits LSB first, bit i driven on tx from edge k+(1+i)*CLKS_PER_BIT for exactly CLKS_PER_BIT cycles, for i = 0..n-1.
REQ-016 STOP SHALL drive tx=1 from edge k+(n+1)*CLKS_PER_BIT for CLKS_PER_BIT cycles.
REQ-017 At edge k+(n+2)*CLKS_PER_BIT the block SHALL enter IDLE and set ready<=1 and done<=1; done SHALL drop at the following edge.
REQ-018 The total frame length SHALL be (n+2)*CLKS_PER_BIT cycles; the minimum start-to-start spacing SHALL be (n+2)*CLKS_PER_BIT+1 cycles (start accepted in the done cycle begins the next frame).
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary; with CLKS_PER_BIT=1 every cycle SHALL be a bit boundary.
REQ-020 The bit counter SHALL count 0..n-1 in DATA and clear on DATA exit; n=1 SHALL produce a single data bit.
REQ-021 Counter widths SHALL be max(1, clog2(CLKS_PER_BIT)) and max(1, clog2(n)).
REQ-022 In IDLE tx SHALL be 1, and done SHALL be 0 except during the completion pulse.

Reset
REQ-023 When rst=1 the block SHALL immediately, independent of clk, set state=IDLE, tx=1, ready=1, done=0, and clear the shift register and counters.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no done pulse; tx SHALL return high at once.
REQ-025 After rst deasserts, start at the first rising edge SHALL be accepted.

Verification
REQ-026 The bench SHALL cover: n=16, CLKS_PER_BIT=4, in0=16'hA5C3, start 1 cycle -> tx low 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (4 cycles each), high 4 cycles; done pulses once at cycle 72 after acceptance; ready low for 72 cycles.
REQ-027 The bench SHALL cover: start held high continuously with in0=16'h0001 then 16'hFFFF -> back-to-back frames 73 cycles apart; second frame carries 16'hFFFF only if in0 changed before the done cycle.
REQ-028 The bench SHALL cover: start pulsed at cycle 10 of a frame with a different in0 -> ignored; frame data unchanged; exactly one done.
REQ-029 The bench SHALL cover: rst asserted at cycle 30 of a frame, asynchronously between edges -> tx=1, ready=1, done=0 immediately; no done pulse; next start sends a full, correct frame.
REQ-030 The bench SHALL cover: n=8, CLKS_PER_BIT=1, in0=8'h80 -> tx sequence 0,0,0,0,0,0,0,0,1,1 over 10 cycles; done at cycle 10.
REQ-031 The bench SHALL cover: n=1, CLKS_PER_BIT=3, in0=1 -> tx 0,0,0,1,1,1,1,1,1; done at cycle 9.
